scan_move_sequencer: RTL and testbench

Turns each scan-step request (send_setup_moves pulse plus step counter) into the cube-move sequence that brings the next sticker under the colour sensors. Issues the moves one at a time to the motor driver. After the last move completes and a mechanical settle time elapses, it raises color_sensor_stable. Sits between the scan-state FSM and the motor driver; it is the responder side of the send_setup_moves / color_sensor_stable handshake.

---
 rtl/scan_move_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_scan_move_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_move_sequencer.sv
// Expands a scan-step request into the cube-move sequence that parks the next sticker
// under the colour sensors, issues it to the motor driver, then waits a settle time.
module scan_move_sequencer #(
    parameter int SETTLE_CYCLES = 2500000,
    parameter int NUM_STEPS     = 49
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send_setup_moves,
    input  logic [5:0] counter,
    output logic       move_valid,
    output logic [4:0] move,
    input  logic       move_ready,
    input  logic       motor_done,
    output logic       color_sensor_stable,
    output logic       busy,
    output logic       overrun
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    // {face[2:0], dir[1:0]}: P suffix is counter-clockwise, 2 suffix is a half turn
    localparam logic [4:0] MV_U  = 5'd0,  MV_UP = 5'd1;
    localparam logic [4:0] MV_L  = 5'd4,  MV_LP = 5'd5,  MV_L2 = 5'd6;
    localparam logic [4:0] MV_F  = 5'd8,  MV_FP = 5'd9,  MV_F2 = 5'd10;
    localparam logic [4:0] MV_R  = 5'd12, MV_RP = 5'd13, MV_R2 = 5'd14;
    localparam logic [4:0] MV_B  = 5'd16, MV_BP = 5'd17, MV_B2 = 5'd18;

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_DONE, SETTLE, READY} state_t;

    state_t           state;
    logic [5:0]       k_reg;
    logic [3:0]       len;
    logic [3:0]       ptr;
    logic [CNT_W-1:0] cnt;

    function automatic logic [29:0] pack6(input logic [4:0] m0, input logic [4:0] m1,
                                          input logic [4:0] m2, input logic [4:0] m3,
                                          input logic [4:0] m4, input logic [4:0] m5);
        return {m5, m4, m3, m2, m1, m0};
    endfunction

    function automatic logic [4:0] pick(input logic [29:0] row, input logic [3:0] idx);
        case (idx)
            4'd0:    return row[4:0];
            4'd1:    return row[9:5];
            4'd2:    return row[14:10];
            4'd3:    return row[19:15];
            4'd4:    return row[24:20];
            4'd5:    return row[29:25];
            default: return 5'd0;
        endcase
    endfunction

    // Setup b: corners 0..5, edges 6..11
    function automatic logic [2:0] setup_len(input logic [3:0] b);
        case (b)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5: return 3'd2;
            4'd7, 4'd8, 4'd9, 4'd10:      return 3'd6;
            4'd11:                        return 3'd4;
            default:                      return 3'd0;
        endcase
    endfunction

    function automatic logic [29:0] setup_row(input logic [3:0] b);
        case (b)
            4'd1:    return pack6(MV_F,  MV_BP, 5'd0,  5'd0,  5'd0,  5'd0);
            4'd2:    return pack6(MV_LP, MV_R,  5'd0,  5'd0,  5'd0,  5'd0);
            4'd3:    return pack6(MV_FP, MV_B,  5'd0,  5'd0,  5'd0,  5'd0);
            4'd4:    return pack6(MV_L,  MV_RP, 5'd0,  5'd0,  5'd0,  5'd0);
            4'd5:    return pack6(MV_L2, MV_R2, 5'd0,  5'd0,  5'd0,  5'd0);
            4'd7:    return pack6(MV_F,  MV_BP, MV_L,  MV_U,  MV_F,  MV_BP);
            4'd8:    return pack6(MV_LP, MV_R,  MV_F,  MV_UP, MV_LP, MV_R);
            4'd9:    return pack6(MV_FP, MV_B,  MV_R,  MV_U,  MV_FP, MV_B);
            4'd10:   return pack6(MV_L,  MV_RP, MV_BP, MV_U,  MV_L,  MV_RP);
            4'd11:   return pack6(MV_R2, MV_L2, MV_F2, MV_B2, 5'd0,  5'd0);
            default: return 30'd0;
        endcase
    endfunction

    // Undo of setup b: reversed and inverted; opposite-face pairs commute, so each pair
    // keeps its written order
    function automatic logic [29:0] undo_row(input logic [3:0] b);
        case (b)
            4'd1:    return pack6(MV_FP, MV_B,  5'd0,  5'd0,  5'd0,  5'd0);
            4'd2:    return pack6(MV_L,  MV_RP, 5'd0,  5'd0,  5'd0,  5'd0);
            4'd3:    return pack6(MV_F,  MV_BP, 5'd0,  5'd0,  5'd0,  5'd0);
            4'd4:    return pack6(MV_LP, MV_R,  5'd0,  5'd0,  5'd0,  5'd0);
            4'd5:    return pack6(MV_L2, MV_R2, 5'd0,  5'd0,  5'd0,  5'd0);
            4'd7:    return pack6(MV_FP, MV_B,  MV_UP, MV_LP, MV_FP, MV_B);
            4'd8:    return pack6(MV_L,  MV_RP, MV_U,  MV_FP, MV_L,  MV_RP);
            4'd9:    return pack6(MV_F,  MV_BP, MV_UP, MV_RP, MV_F,  MV_BP);
            4'd10:   return pack6(MV_LP, MV_R,  MV_UP, MV_B,  MV_LP, MV_R);
            4'd11:   return pack6(MV_F2, MV_B2, MV_R2, MV_L2, 5'd0,  5'd0);
            default: return 30'd0;
        endcase
    endfunction

    function automatic logic [3:0] seq_len(input logic [5:0] k);
        logic [3:0] b;
        b = k[5:2];
        if (k == 6'd0 || int'(k) >= NUM_STEPS)
            return 4'd0;
        else if (k[1:0] != 2'd0)
            return 4'd1;
        else
            return 4'd1 + {1'b0, setup_len(b - 4'd1)} + {1'b0, setup_len(b)};
    endfunction

    // Step 4b: U, undo of setup b-1, then setup b
    function automatic logic [4:0] seq_move(input logic [5:0] k, input logic [3:0] p);
        logic [3:0] b;
        logic [3:0] i;
        logic [3:0] li;
        b  = k[5:2];
        i  = p - 4'd1;
        li = {1'b0, setup_len(b - 4'd1)};
        if (p == 4'd0)
            return MV_U;
        else if (i < li)
            return pick(undo_row(b - 4'd1), i);
        else
            return pick(setup_row(b), i - li);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            move_valid          <= 1'b0;
            move                <= 5'd0;
            color_sensor_stable <= 1'b0;
            busy                <= 1'b0;
            overrun             <= 1'b0;
            k_reg               <= 6'd0;
            len                 <= 4'd0;
            ptr                 <= 4'd0;
            cnt                 <= '0;
        end else begin
            if (send_setup_moves && state != IDLE && state != READY)
                overrun <= 1'b1;
            case (state)
                IDLE, READY: begin
                    if (send_setup_moves) begin
                        k_reg               <= counter;
                        len                 <= seq_len(counter);
                        color_sensor_stable <= 1'b0;
                        busy                <= 1'b1;
                        state               <= LOAD;
                    end
                end
                LOAD: begin
                    ptr <= 4'd0;
                    if (len == 4'd0) begin
                        cnt   <= '0;
                        state <= SETTLE;
                    end else begin
                        move_valid <= 1'b1;
                        move       <= seq_move(k_reg, 4'd0);
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (move_ready) begin
                        move_valid <= 1'b0;
                        state      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (motor_done) begin
                        if (ptr == len - 4'd1) begin
                            // The done cycle itself counts as the first settle cycle
                            if (SETTLE_CYCLES == 1) begin
                                color_sensor_stable <= 1'b1;
                                busy                <= 1'b0;
                                state               <= READY;
                            end else begin
                                cnt   <= CNT_W'(1);
                                state <= SETTLE;
                            end
                        end else begin
                            ptr        <= ptr + 4'd1;
                            move       <= seq_move(k_reg, ptr + 4'd1);
                            move_valid <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        color_sensor_stable <= 1'b1;
                        busy                <= 1'b0;
                        state               <= READY;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_move_sequencer.sv
// Directed bench for scan_move_sequencer: hand-computed move lists, handshake timing,
// overrun, spurious completions and reset abandonment.
module tb_scan_move_sequencer;

    localparam int SETTLE = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       send_setup_moves = 1'b0;
    logic [5:0] counter = 6'd0;
    logic       move_ready = 1'b0;
    logic       motor_done = 1'b0;
    logic       move_valid;
    logic [4:0] move;
    logic       color_sensor_stable;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_mv [13];

    scan_move_sequencer #(.SETTLE_CYCLES(SETTLE), .NUM_STEPS(49)) dut (
        .clock               (clock),
        .reset               (reset),
        .send_setup_moves    (send_setup_moves),
        .counter             (counter),
        .move_valid          (move_valid),
        .move                (move),
        .move_ready          (move_ready),
        .motor_done          (motor_done),
        .color_sensor_stable (color_sensor_stable),
        .busy                (busy),
        .overrun             (overrun)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   int'(move_valid), 0);
        check({tag, "_move"},    int'(move), 0);
        check({tag, "_stable"},  int'(color_sensor_stable), 0);
        check({tag, "_busy"},    int'(busy), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    task automatic strobe(input logic [5:0] k, input string tag);
        send_setup_moves = 1'b1;
        counter = k;
        step();
        send_setup_moves = 1'b0;
        counter = 6'd63;
        check({tag, "_load_stable"}, int'(color_sensor_stable), 0);
        check({tag, "_load_busy"},   int'(busy), 1);
        check({tag, "_load_valid"},  int'(move_valid), 0);
    endtask

    task automatic run_empty(input logic [5:0] k, input string tag);
        strobe(k, tag);
        for (int c = 0; c < SETTLE; c++) begin
            step();
            check({tag, "_settle_busy"},   int'(busy), 1);
            check({tag, "_settle_stable"}, int'(color_sensor_stable), 0);
            check({tag, "_settle_valid"},  int'(move_valid), 0);
        end
        step();
        check({tag, "_stable"}, int'(color_sensor_stable), 1);
        check({tag, "_idle"},   int'(busy), 0);
    endtask

    // lag: cycles move_ready stays low; strobe_at/spur_at: move index for extra events
    task automatic run_seq(input logic [5:0] k, input int n, input int lag, input logic tied,
                           input int strobe_at, input int spur_at, input string tag);
        move_ready = tied;
        strobe(k, tag);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            while (!move_valid && w < 8) begin
                step();
                w++;
            end
            check({tag, "_valid"}, int'(move_valid), 1);
            check({tag, "_move"},  int'(move), int'(exp_mv[i]));
            for (int j = 0; j < lag; j++) begin
                if (i == spur_at && j == 0) motor_done = 1'b1;
                step();
                motor_done = 1'b0;
                check({tag, "_hold_valid"}, int'(move_valid), 1);
                check({tag, "_hold_move"},  int'(move), int'(exp_mv[i]));
            end
            move_ready = 1'b1;
            step();
            move_ready = tied;
            check({tag, "_accept_drop"}, int'(move_valid), 0);
            if (i == strobe_at) begin
                send_setup_moves = 1'b1;
                counter = 6'd3;
            end
            step();
            send_setup_moves = 1'b0;
            counter = 6'd63;
            step();
            check({tag, "_wait_valid"}, int'(move_valid), 0);
            motor_done = 1'b1;
            step();
            motor_done = 1'b0;
        end
        for (int c = 1; c < SETTLE; c++) begin
            check({tag, "_settle_stable"}, int'(color_sensor_stable), 0);
            check({tag, "_settle_busy"},   int'(busy), 1);
            check({tag, "_settle_valid"},  int'(move_valid), 0);
            step();
        end
        check({tag, "_stable"}, int'(color_sensor_stable), 1);
        check({tag, "_idle"},   int'(busy), 0);
        check({tag, "_no_extra"}, int'(move_valid), 0);
        move_ready = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        run_empty(6'd0, "k0");

        exp_mv = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        run_seq(6'd5, 1, 0, 1'b1, -1, -1, "k5");

        exp_mv = '{5'd0, 5'd9, 5'd16, 5'd5, 5'd12, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        run_seq(6'd8, 5, 0, 1'b0, -1, -1, "k8");

        exp_mv = '{5'd0, 5'd6, 5'd14, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        run_seq(6'd24, 3, 7, 1'b0, -1, -1, "k24");

        exp_mv = '{5'd0, 5'd10, 5'd18, 5'd14, 5'd6, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        run_seq(6'd48, 5, 1, 1'b0, -1, -1, "k48");
        check("overrun_clear", int'(overrun), 0);

        exp_mv = '{5'd0, 5'd5, 5'd12, 5'd6, 5'd14, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        run_seq(6'd20, 5, 2, 1'b0, 1, 2, "k20");
        check("overrun_set", int'(overrun), 1);

        strobe(6'd44, "k44");
        step();
        check("k44_m0_valid", int'(move_valid), 1);
        check("k44_m0", int'(move), 0);
        move_ready = 1'b1;
        step();
        move_ready = 1'b0;
        step();
        motor_done = 1'b1;
        step();
        motor_done = 1'b0;
        check("k44_m1_valid", int'(move_valid), 1);
        check("k44_m1", int'(move), 5);
        move_ready = 1'b1;
        step();
        move_ready = 1'b0;
        check("k44_wait_valid", int'(move_valid), 0);
        check("k44_wait_busy", int'(busy), 1);
        reset = 1'b1;
        step();
        check_all_zero("k44_reset");
        reset = 1'b0;
        motor_done = 1'b1;
        step();
        motor_done = 1'b0;
        check("late_done_busy", int'(busy), 0);
        check("late_done_valid", int'(move_valid), 0);
        step();
        check("late_done_valid2", int'(move_valid), 0);

        run_empty(6'd52, "k52");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
